// File: rtl/display_source_scheduler.sv
// rtl/display_source_scheduler.sv - round-robin source picker with double-dabble BCD conversion for a 4-digit display
module display_source_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int CNT_W        = 27,
    localparam int SEL_W       = $clog2(NUM_SRC)
) (
    input  logic                  clock_100Mhz,
    input  logic                  reset,
    input  logic [16*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic                  hold,
    input  logic                  advance,
    output logic [15:0]           bcd_digits,
    output logic                  overflow,
    output logic [SEL_W-1:0]      src_sel,
    output logic                  update,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_SELECT,
        S_CAPTURE,
        S_CONVERT,
        S_PUBLISH,
        S_WAIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   candidate;
    logic               first_pick;
    logic [35:0]        sr;
    logic [35:0]        sr_adj;
    logic [35:0]        sr_step;
    logic [3:0]         iter;
    logic [CNT_W-1:0]   dwell_cnt;
    logic               pending;

    logic               found;
    logic [SEL_W-1:0]   scan_idx;
    logic               hold_keep;
    logic               pick_ok;
    logic [SEL_W-1:0]   pick_idx;
    logic               dwell_done;
    logic               step_req;
    logic               leave_wait;

    // Lowest-offset enabled source starting from index 0 after reset, else from src_sel+1 with wrap.
    always_comb begin
        int start;
        int idx;
        logic [SEL_W-1:0] idx_s;
        found    = 1'b0;
        scan_idx = '0;
        idx      = 0;
        idx_s    = '0;
        start    = first_pick ? 0 : (int'(src_sel) + 1) % NUM_SRC;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx   = (start + k) % NUM_SRC;
            idx_s = SEL_W'(idx);
            if (src_valid[idx_s]) begin
                found    = 1'b1;
                scan_idx = idx_s;
            end
        end
    end

    assign hold_keep  = hold && src_valid[src_sel];
    assign pick_ok    = hold_keep || found;
    assign pick_idx   = hold_keep ? src_sel : scan_idx;
    assign dwell_done = (dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
    assign step_req   = !hold && (pending || advance);
    assign leave_wait = dwell_done || step_req;

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < 5; d++) begin
            if (sr_adj[16+4*d +: 4] >= 4'd5) begin
                sr_adj[16+4*d +: 4] = sr_adj[16+4*d +: 4] + 4'd3;
            end
        end
        sr_step = {sr_adj[34:0], 1'b0};
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state <= S_SELECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SELECT:  state_nxt = pick_ok ? S_CAPTURE : S_WAIT;
            S_CAPTURE: state_nxt = S_CONVERT;
            S_CONVERT: state_nxt = (iter == 4'd15) ? S_PUBLISH : S_CONVERT;
            S_PUBLISH: state_nxt = S_WAIT;
            S_WAIT:    state_nxt = leave_wait ? S_SELECT : S_WAIT;
            default:   state_nxt = S_SELECT;
        endcase
    end

    always_comb begin
        busy   = (state == S_CAPTURE) || (state == S_CONVERT);
        update = (state == S_PUBLISH);
    end

    // Display registers load on the last conversion edge so they become visible with the update pulse.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            candidate  <= '0;
            first_pick <= 1'b1;
            sr         <= '0;
            iter       <= '0;
            dwell_cnt  <= '0;
            bcd_digits <= '0;
            overflow   <= 1'b0;
            src_sel    <= '0;
        end else begin
            case (state)
                S_SELECT: begin
                    if (pick_ok) begin
                        candidate <= pick_idx;
                    end
                end
                S_CAPTURE: begin
                    sr   <= {20'b0, src_data[16*candidate +: 16]};
                    iter <= '0;
                end
                S_CONVERT: begin
                    sr   <= sr_step;
                    iter <= iter + 4'd1;
                    if (iter == 4'd15) begin
                        if (sr_step[35:32] != 4'd0) begin
                            bcd_digits <= 16'h9999;
                            overflow   <= 1'b1;
                        end else begin
                            bcd_digits <= sr_step[31:16];
                            overflow   <= 1'b0;
                        end
                        src_sel    <= candidate;
                        first_pick <= 1'b0;
                    end
                end
                S_PUBLISH: begin
                    dwell_cnt <= '0;
                end
                S_WAIT: begin
                    dwell_cnt <= leave_wait ? '0 : dwell_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Advance requests arriving while a value is in flight collapse into a single deferred step.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (hold) begin
            pending <= 1'b0;
        end else if (state == S_WAIT && leave_wait) begin
            pending <= 1'b0;
        end else if (advance && (state == S_CAPTURE || state == S_CONVERT || state == S_PUBLISH)) begin
            pending <= 1'b1;
        end
    end

endmodule
